// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter and frame sequencer for shift_divide (req_valid/req_data0/req_data1 in, req_ready/data_send/tx_ctrl/enable_s/busy/frame_done/grant_id out)
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT   = 4,
  parameter int BITS_PER_FRAME = 10,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [7:0] data_send,
  output logic       tx_ctrl,
  output logic       enable_s,
  output logic       busy,
  output logic       frame_done,
  output logic       grant_id
);
  localparam int BW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = BITS_PER_FRAME > 2 ? $clog2(BITS_PER_FRAME) : 1;
  localparam int GW = GAP_CYCLES > 2 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t        state_q;
  logic          rr_q, tx_q, en_q, busy_q, done_q, gid_q;
  logic [BW-1:0] baud_q;
  logic [NW-1:0] bit_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    data_q;
  logic          any, g, baud_end;
  assign any       = |req_valid;
  assign g         = req_valid == 2'b11 ? rr_q : req_valid[1];
  assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
  assign req_ready = (state_q == IDLE && !rst && any) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign data_send  = data_q;
  assign tx_ctrl    = tx_q;
  assign enable_s   = en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign grant_id   = gid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      tx_q   <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          data_q  <= g ? req_data1 : req_data0;
          gid_q   <= g;
          rr_q    <= ~g;
          tx_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          // tick is registered one cycle ahead so it lands on baud_cnt == CLKS_PER_BIT-1
          en_q   <= baud_q == BW'(CLKS_PER_BIT - 2);
          baud_q <= baud_end ? '0 : baud_q + 1'b1;
          if (baud_end) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == NW'(BITS_PER_FRAME - 1)) begin
              gap_q   <= '0;
              done_q  <= 1'b1;
              state_q <= GAP;
            end
          end
        end
        GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else gap_q <= gap_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, valid_b, ready_a, ready_b;
  logic [7:0] data0, data1, send_a, send_b;
  logic       tx_a, en_a, busy_a, done_a, gid_a;
  logic       tx_b, en_b, busy_b, done_b, gid_b;
  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  uart_tx_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(data0), .req_data1(data1),
    .req_ready(ready_a), .data_send(send_a), .tx_ctrl(tx_a), .enable_s(en_a),
    .busy(busy_a), .frame_done(done_a), .grant_id(gid_a)
  );
  uart_tx_scheduler #(.CLKS_PER_BIT(2), .BITS_PER_FRAME(3), .GAP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_data0(data0), .req_data1(data1),
    .req_ready(ready_b), .data_send(send_b), .tx_ctrl(tx_b), .enable_s(en_b),
    .busy(busy_b), .frame_done(done_b), .grant_id(gid_b)
  );
  task automatic step;
    @(negedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy_a !== 1'b0 && n < 100) begin
      step;
      n++;
    end
    asserts++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b expected 0 within 100 cycles", busy_a);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    valid_b = 2'b00;
    data0 = 8'h11;
    data1 = 8'h22;
    step;
    step;
    asserts++;
    if (ready_a !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 00", ready_a);
    end
    asserts++;
    if ({tx_a, en_a, busy_a, done_a, gid_a} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {tx_a, en_a, busy_a, done_a, gid_a});
    end
    asserts++;
    if (send_a !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h expected 00", send_a);
    end
    rst = 1'b0;
    #1;
    asserts++;
    if (ready_a !== 2'b01) begin
      fails++;
      $display("FAIL reset_first_grant: got %b expected 01", ready_a);
    end
    step;
    req_valid = 2'b00;
    asserts++;
    if ({gid_a, send_a, tx_a} !== {1'b0, 8'h11, 1'b1}) begin
      fails++;
      $display("FAIL reset_first_load: got gid=%b data=%h tx=%b expected 0 11 1", gid_a, send_a, tx_a);
    end
    wait_idle;
  endtask
  task automatic test_single;
    logic [63:0] en_m = '0, en_e = '0, tx_m = '0, tx_e = '0, dn_m = '0, dn_e = '0, bz_m = '0, bz_e = '0;
    for (int k = 1; k <= 10; k++) en_e[1 + 4 * k] = 1'b1;
    for (int k = 1; k <= 43; k++) bz_e[k] = 1'b1;
    tx_e[1] = 1'b1;
    dn_e[42] = 1'b1;
    req_valid = 2'b01;
    data0 = 8'hD3;
    #1;
    asserts++;
    if (ready_a !== 2'b01) begin
      fails++;
      $display("FAIL single_ready: got %b expected 01", ready_a);
    end
    for (int c = 1; c <= 45; c++) begin
      step;
      if (c == 1) begin
        req_valid = 2'b00;
        asserts++;
        if (send_a !== 8'hD3) begin
          fails++;
          $display("FAIL single_data: got %h expected d3", send_a);
        end
      end
      en_m[c] = en_a;
      tx_m[c] = tx_a;
      dn_m[c] = done_a;
      bz_m[c] = busy_a;
    end
    asserts++;
    if (en_m !== en_e) begin
      fails++;
      $display("FAIL single_enable: got %h expected %h", en_m, en_e);
    end
    asserts++;
    if (tx_m !== tx_e) begin
      fails++;
      $display("FAIL single_txctrl: got %h expected %h", tx_m, tx_e);
    end
    asserts++;
    if (dn_m !== dn_e) begin
      fails++;
      $display("FAIL single_done: got %h expected %h", dn_m, dn_e);
    end
    asserts++;
    if (bz_m !== bz_e) begin
      fails++;
      $display("FAIL single_busy: got %h expected %h", bz_m, bz_e);
    end
  endtask
  task automatic test_contention;
    int n = 0;
    int last = 0;
    logic eg;
    rst = 1'b1;
    step;
    rst = 1'b0;
    data0 = 8'hA5;
    data1 = 8'h3C;
    req_valid = 2'b11;
    #1;
    cyc = 0;
    while (n < 4 && cyc < 300) begin
      if (ready_a !== 2'b00) begin
        eg = n[0];
        asserts++;
        if (ready_a !== (eg ? 2'b10 : 2'b01)) begin
          fails++;
          $display("FAIL contention_ready%0d: got %b expected %b", n, ready_a, eg ? 2'b10 : 2'b01);
        end
        if (n > 0) begin
          asserts++;
          if (cyc - last != 44) begin
            fails++;
            $display("FAIL contention_spacing%0d: got %0d expected 44", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        step;
        asserts++;
        if ({gid_a, send_a} !== {eg, eg ? 8'h3C : 8'hA5}) begin
          fails++;
          $display("FAIL contention_load%0d: got gid=%b data=%h expected %b %h", n, gid_a, send_a, eg, eg ? 8'h3C : 8'hA5);
        end
      end else step;
    end
    asserts++;
    if (n != 4) begin
      fails++;
      $display("FAIL contention_timeout: got %0d grants expected 4", n);
    end
    req_valid = 2'b00;
    wait_idle;
  endtask
  task automatic test_busy_request;
    logic bad = 1'b0;
    req_valid = 2'b01;
    data0 = 8'h55;
    data1 = 8'hC7;
    #1;
    asserts++;
    if (ready_a !== 2'b01) begin
      fails++;
      $display("FAIL busyreq_first: got %b expected 01", ready_a);
    end
    for (int c = 1; c <= 45; c++) begin
      step;
      if (c == 1) req_valid = 2'b00;
      if (c == 10) begin
        req_valid = 2'b10;
        #1;
      end
      if (c >= 10 && c < 44 && ready_a !== 2'b00) bad = 1'b1;
      if (c == 44) begin
        asserts++;
        if (ready_a !== 2'b10) begin
          fails++;
          $display("FAIL busyreq_grant: got %b expected 10", ready_a);
        end
        asserts++;
        if (send_a !== 8'h55) begin
          fails++;
          $display("FAIL busyreq_hold: got %h expected 55", send_a);
        end
      end
      if (c == 45) begin
        req_valid = 2'b00;
        asserts++;
        if ({gid_a, send_a, tx_a} !== {1'b1, 8'hC7, 1'b1}) begin
          fails++;
          $display("FAIL busyreq_load: got gid=%b data=%h tx=%b expected 1 c7 1", gid_a, send_a, tx_a);
        end
      end
    end
    asserts++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL busyreq_early_ready: got 1 expected 0");
    end
    wait_idle;
  endtask
  task automatic test_reset_mid;
    logic bad = 1'b0;
    req_valid = 2'b01;
    data0 = 8'h9A;
    #1;
    for (int c = 1; c <= 20; c++) begin
      step;
      if (c == 1) req_valid = 2'b00;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    asserts++;
    if ({en_a, busy_a, tx_a, done_a} !== 4'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b expected 0000", {en_a, busy_a, tx_a, done_a});
    end
    for (int c = 0; c < 30; c++) begin
      step;
      if (done_a || en_a || busy_a) bad = 1'b1;
    end
    asserts++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL midreset_quiet: got activity expected none");
    end
    req_valid = 2'b11;
    data0 = 8'h4B;
    #1;
    asserts++;
    if (ready_a !== 2'b01) begin
      fails++;
      $display("FAIL midreset_rr: got %b expected 01", ready_a);
    end
    step;
    req_valid = 2'b00;
    asserts++;
    if ({gid_a, send_a, tx_a} !== {1'b0, 8'h4B, 1'b1}) begin
      fails++;
      $display("FAIL midreset_regrant: got gid=%b data=%h tx=%b expected 0 4b 1", gid_a, send_a, tx_a);
    end
    wait_idle;
  endtask
  task automatic test_params;
    logic [15:0] en_m = '0, en_e = 16'h00A8, dn_m = '0, dn_e = 16'h0100, bz_m = '0, bz_e = 16'h01FE;
    valid_b = 2'b01;
    data0 = 8'h5E;
    #1;
    asserts++;
    if (ready_b !== 2'b01) begin
      fails++;
      $display("FAIL params_ready: got %b expected 01", ready_b);
    end
    for (int c = 1; c <= 9; c++) begin
      step;
      if (c == 1) begin
        valid_b = 2'b00;
        asserts++;
        if ({send_b, tx_b} !== {8'h5E, 1'b1}) begin
          fails++;
          $display("FAIL params_load: got data=%h tx=%b expected 5e 1", send_b, tx_b);
        end
      end
      en_m[c] = en_b;
      dn_m[c] = done_b;
      bz_m[c] = busy_b;
    end
    valid_b = 2'b10;
    #1;
    asserts++;
    if (ready_b !== 2'b10) begin
      fails++;
      $display("FAIL params_idle_grant: got %b expected 10", ready_b);
    end
    valid_b = 2'b00;
    asserts++;
    if (en_m !== en_e) begin
      fails++;
      $display("FAIL params_enable: got %h expected %h", en_m, en_e);
    end
    asserts++;
    if (dn_m !== dn_e) begin
      fails++;
      $display("FAIL params_done: got %h expected %h", dn_m, dn_e);
    end
    asserts++;
    if (bz_m !== bz_e) begin
      fails++;
      $display("FAIL params_busy: got %h expected %h", bz_m, bz_e);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_busy_request;
    test_reset_mid;
    test_params;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Controller and arbiter for the shift_divide byte serializer.
- Accepts bytes from two independent requesters and picks between them with round-robin arbitration.
- Sequences each frame: one-cycle tx_ctrl load pulse, then a baud-rate enable_s tick train for a fixed number of bit periods, then an inter-frame gap.
- Sits between the producer logic and shift_divide, and drives all of shift_divide's control and data inputs.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per bit period; enable_s pulses once per period; legal range ≥2.
- BITS_PER_FRAME, 10, enable_s ticks per frame (start + 8 data + stop).
- GAP_CYCLES, 2, idle cycles after a frame before the next grant; legal range ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester byte-valid; held until the matching req_ready is seen.
- req_data0  in  8  byte from requester 0.
- req_data1  in  8  byte from requester 1.
- req_ready  out  2  one-hot grant/accept; byte consumed in the cycle req_valid[i]&req_ready[i].
- data_send  out  8  latched byte to shift_divide.
- tx_ctrl  out  1  one-cycle load strobe to shift_divide.
- enable_s  out  1  one-cycle baud tick to shift_divide.
- busy  out  1  high from LOAD through end of GAP.
- frame_done  out  1  one-cycle pulse on the first GAP cycle.
- grant_id  out  1  index of the requester whose byte is in flight.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled on the clk rising edge.
- Reset state: FSM in IDLE; rr_ptr=0; baud and bit counters=0; data_send=8'h00; all outputs 0.
- Reset mid-frame: frame aborts on that edge, no frame_done, rr_ptr returns to 0.

FSM states: IDLE, LOAD, SEND, GAP.

IDLE:
- req_ready is Mealy (combinational).
- If exactly one req_valid bit is high, grant it.
- If both are high, grant rr_ptr.
- In the grant cycle, req_ready[g]=1.
- At the end of the cycle: latch the selected data into data_send, set grant_id=g, set rr_ptr=~g, go to LOAD.
- No valid: stay in IDLE, req_ready=0.
- A req_valid that drops before being granted is not recorded.

LOAD (1 cycle):
- tx_ctrl=1, busy=1.
- data_send is stable from this cycle until the next grant.
- Clear the baud and bit counters; go to SEND.

SEND:
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps.
- enable_s=1 exactly in cycles where baud_cnt==CLKS_PER_BIT-1.
- bit_cnt increments on each enable_s.
- On the cycle of the BITS_PER_FRAME-th tick, go to GAP.
- tx_ctrl stays 0.

GAP:
- Lasts GAP_CYCLES cycles; enable_s=0.
- frame_done=1 in the first GAP cycle only.
- Then go to IDLE.

Other rules:
- enable_s and tx_ctrl are never high outside SEND and LOAD respectively.
- They are never both high in the same cycle.
- req_ready is never asserted outside IDLE; requests made during busy wait.

Timing:
- Relative to the grant cycle (cycle 0): LOAD at cycle 1; SEND from cycle 2 for CLKS_PER_BIT*BITS_PER_FRAME cycles; GAP follows; next grant possible at cycle 2+CLKS_PER_BIT*BITS_PER_FRAME+GAP_CYCLES.
- Defaults: SEND is cycles 2..41; enable_s at cycles 5,9,…,41; frame_done at 42; IDLE at 44.

Counter widths: $clog2 of each terminal value, minimum 1 bit.

Test Plan:
1. Reset: rst high for 2 cycles while req_valid=2'b11 → all outputs 0, req_ready=0; after release, first grant goes to requester 0.
2. Single byte: req_valid=2'b01, req_data0=8'hD3 → req_ready=2'b01 at cycle 0; tx_ctrl at cycle 1 with data_send=8'hD3; exactly 10 enable_s pulses at cycles 5,9,…,41; frame_done at 42; busy cycles 1–43.
3. Contention: req_valid=2'b11 held, data0=8'hA5, data1=8'h3C → grants alternate 0,1,0,1; grant_id and data_send match; successive grants 44 cycles apart.
4. Request while busy: assert req_valid[1] at cycle 10 of requester 0's frame → no req_ready until cycle 44, then req_ready=2'b10 and data_send loads data1 at cycle 45.
5. Reset mid-frame: rst at cycle 20 → next cycle enable_s=0, busy=0, no frame_done; a new request is granted normally afterwards.
6. Parameter check: CLKS_PER_BIT=2, BITS_PER_FRAME=3, GAP_CYCLES=1 → enable_s at cycles 3,5,7; frame_done at cycle 8; IDLE at cycle 9.
